// File: rtl/grayscale_pkg.sv
// grayscale_pkg: shared types and constants for the HardCloud CSR bank
//   HC_MAX_BUFFERS   upper bound on buffer descriptors
//   HC_CTL_*         control register action codes
//   t_hc_ctl_state   control FSM state encoding (read back through the control register)
//   t_hc_buffer      one buffer descriptor with its written-flags
//   CCI-P MMIO request/response channel structs (MMIO subset only)
package grayscale_pkg;
  localparam int HC_MAX_BUFFERS = 8;
  localparam logic [31:0] HC_CTL_ASSERT_RST   = 32'd0;
  localparam logic [31:0] HC_CTL_DEASSERT_RST = 32'd1;
  localparam logic [31:0] HC_CTL_START        = 32'd3;
  localparam logic [31:0] HC_CTL_STOP         = 32'd7;
  typedef enum logic [2:0] {
    S_CTL_RESET = 3'd0,
    S_CTL_IDLE  = 3'd1,
    S_CTL_RUN   = 3'd2,
    S_CTL_DONE  = 3'd3
  } t_hc_ctl_state;
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] size;
    logic        addr_set;
    logic        size_set;
  } t_hc_buffer;
  typedef struct packed {
    logic [15:0] address;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
endpackage

// File: rtl/hc_ctl_fsm.sv
// hc_ctl_fsm: HardCloud control state machine
//   ctl_wr/ctl_data      decoded control register write and its action code
//   cfg_ready            all buffers valid and DSM address set
//   done_in/dsm_wr_ack   datapath completion pulse, DSM write acknowledge
//   state/soft_reset     current state, held datapath reset
//   start/dsm_wr_req     one-cycle start pulse, DSM completion write request
//   cfg_clear            ASSERT_RST seen: descriptor flags must be dropped
module hc_ctl_fsm
  import grayscale_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ctl_wr,
  input  logic [31:0]   ctl_data,
  input  logic          cfg_ready,
  input  logic          done_in,
  input  logic          dsm_wr_ack,
  output t_hc_ctl_state state,
  output logic          soft_reset,
  output logic          start,
  output logic          dsm_wr_req,
  output logic          cfg_clear
);
  t_hc_ctl_state state_q, state_d;
  logic start_q, start_d, req_q, req_d;
  logic cmd_rst, cmd_run, cmd_go, cmd_stop;
  assign cmd_rst  = ctl_wr && ctl_data == HC_CTL_ASSERT_RST;
  assign cmd_run  = ctl_wr && ctl_data == HC_CTL_DEASSERT_RST;
  assign cmd_go   = ctl_wr && ctl_data == HC_CTL_START;
  assign cmd_stop = ctl_wr && ctl_data == HC_CTL_STOP;
  // STOP is tested before done_in so a same-cycle STOP wins
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    req_d   = req_q && !dsm_wr_ack;
    if (cmd_rst) begin
      state_d = S_CTL_RESET;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        S_CTL_RESET: state_d = cmd_run ? S_CTL_IDLE : S_CTL_RESET;
        S_CTL_IDLE: begin
          start_d = cmd_go && cfg_ready;
          state_d = start_d ? S_CTL_RUN : S_CTL_IDLE;
        end
        S_CTL_RUN: begin
          state_d = cmd_stop ? S_CTL_IDLE : done_in ? S_CTL_DONE : S_CTL_RUN;
          req_d   = cmd_stop ? 1'b0 : done_in ? 1'b1 : req_d;
        end
        S_CTL_DONE: begin
          state_d = cmd_stop ? S_CTL_IDLE : S_CTL_DONE;
          req_d   = req_d && !cmd_stop;
        end
        default: state_d = S_CTL_RESET;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CTL_RESET;
      start_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      req_q   <= req_d;
    end
  end
  assign state      = state_q;
  assign soft_reset = state_q == S_CTL_RESET;
  assign start      = start_q;
  assign dsm_wr_req = req_q;
  assign cfg_clear  = cmd_rst;
endmodule

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: HardCloud MMIO CSR bank (DSM address, control, buffer descriptors)
//   rx_mmio/tx_mmio       CCI-P MMIO request channel in, read response out (1-cycle latency)
//   dsm_base              DSM base byte address
//   buf_addr/size/valid   per-buffer descriptors; valid once both halves written
//   ctl_*                 control FSM state, held reset, start pulse
//   done_in               datapath completion pulse
//   dsm_wr_req/dsm_wr_ack DSM completion write handshake
module hc_csr_bank
  import grayscale_pkg::*;
#(
  parameter int          NUM_BUFFERS = 2,
  parameter logic [15:0] MMIO_BASE   = 16'h110
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  t_if_ccip_c0_Rx               rx_mmio,
  output t_if_ccip_c2_Tx               tx_mmio,
  output logic [63:0]                  dsm_base,
  output logic [NUM_BUFFERS-1:0][63:0] buf_addr,
  output logic [NUM_BUFFERS-1:0][31:0] buf_size,
  output logic [NUM_BUFFERS-1:0]       buf_valid,
  output t_hc_ctl_state                ctl_state,
  output logic                         ctl_soft_reset,
  output logic                         ctl_start,
  input  logic                         done_in,
  output logic                         dsm_wr_req,
  input  logic                         dsm_wr_ack
);
  // MMIO addresses arrive as 32-bit word addresses
  localparam logic [15:0] DSM_W = MMIO_BASE >> 2;
  localparam logic [15:0] CTL_W = (MMIO_BASE + 16'd8) >> 2;
  localparam logic [15:0] BUF_W = (MMIO_BASE + 16'd16) >> 2;
  logic [15:0] addr;
  logic wr, ctl_wr, cfg_clear;
  logic [63:0] dsm_base_q, dsm_base_d, rd_data;
  logic dsm_set_q, dsm_set_d;
  t_hc_buffer [NUM_BUFFERS-1:0] bufs_q, bufs_d;
  t_if_ccip_c2_Tx tx_q;
  assign addr   = rx_mmio.hdr.address;
  assign wr     = rx_mmio.mmioWrValid && addr < 16'h100;
  assign ctl_wr = wr && addr == CTL_W;
  always_comb begin
    dsm_base_d = dsm_base_q;
    dsm_set_d  = dsm_set_q && !cfg_clear;
    bufs_d     = bufs_q;
    rd_data    = '0;
    if (wr && addr == DSM_W) begin
      dsm_base_d = rx_mmio.data;
      dsm_set_d  = 1'b1;
    end
    if (addr == DSM_W) rd_data = dsm_base_q;
    if (addr == CTL_W) rd_data = {61'b0, ctl_state};
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (cfg_clear) begin
        bufs_d[i].addr_set = 1'b0;
        bufs_d[i].size_set = 1'b0;
      end
      if (wr && addr == BUF_W + 16'(4 * i)) begin
        bufs_d[i].addr     = rx_mmio.data;
        bufs_d[i].addr_set = 1'b1;
      end
      if (wr && addr == BUF_W + 16'(4 * i + 2)) begin
        bufs_d[i].size     = rx_mmio.data[31:0];
        bufs_d[i].size_set = 1'b1;
      end
      if (addr == BUF_W + 16'(4 * i)) rd_data = bufs_q[i].addr;
      if (addr == BUF_W + 16'(4 * i + 2)) rd_data = {32'b0, bufs_q[i].size};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dsm_base_q <= '0;
      dsm_set_q  <= 1'b0;
      bufs_q     <= '0;
      tx_q       <= '0;
    end else begin
      dsm_base_q       <= dsm_base_d;
      dsm_set_q        <= dsm_set_d;
      bufs_q           <= bufs_d;
      tx_q.mmioRdValid <= rx_mmio.mmioRdValid;
      tx_q.hdr.tid     <= rx_mmio.hdr.tid;
      tx_q.data        <= rd_data;
    end
  end
  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
    assign buf_addr[g]  = bufs_q[g].addr;
    assign buf_size[g]  = bufs_q[g].size;
    assign buf_valid[g] = bufs_q[g].addr_set && bufs_q[g].size_set;
  end
  assign dsm_base = dsm_base_q;
  assign tx_mmio  = tx_q;
  hc_ctl_fsm u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctl_wr     (ctl_wr),
    .ctl_data   (rx_mmio.data[31:0]),
    .cfg_ready  (&buf_valid && dsm_set_q),
    .done_in    (done_in),
    .dsm_wr_ack (dsm_wr_ack),
    .state      (ctl_state),
    .soft_reset (ctl_soft_reset),
    .start      (ctl_start),
    .dsm_wr_req (dsm_wr_req),
    .cfg_clear  (cfg_clear)
  );
endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank: randomized scoreboard bench for hc_csr_bank against a register-map model
module tb_hc_csr_bank;
  import grayscale_pkg::*;
  localparam int NB = 2;
  localparam int MB = 'h110;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, done_in, dsm_wr_ack, ctl_soft_reset, ctl_start, dsm_wr_req;
  t_if_ccip_c0_Rx rx;
  t_if_ccip_c2_Tx tx;
  logic [63:0] dsm_base;
  logic [NB-1:0][63:0] buf_addr;
  logic [NB-1:0][31:0] buf_size;
  logic [NB-1:0] buf_valid;
  t_hc_ctl_state ctl_state;
  hc_csr_bank #(.NUM_BUFFERS(NB), .MMIO_BASE(16'h110)) dut (
    .clk(clk), .reset_n(reset_n), .rx_mmio(rx), .tx_mmio(tx), .dsm_base(dsm_base),
    .buf_addr(buf_addr), .buf_size(buf_size), .buf_valid(buf_valid), .ctl_state(ctl_state),
    .ctl_soft_reset(ctl_soft_reset), .ctl_start(ctl_start), .done_in(done_in),
    .dsm_wr_req(dsm_wr_req), .dsm_wr_ack(dsm_wr_ack)
  );
  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; logic [8:0] tid; logic [63:0] data;} exp_t;
  exp_t exp_q[$];
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask
  // response monitor: every presented response must match the oldest expected one, on time
  always @(negedge clk) begin
    exp_t e;
    if (tx.mmioRdValid === 1'b1) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rsp_tid", 64'(tx.hdr.tid), 64'(e.tid));
        check("rsp_data", tx.data, e.data);
        check("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      void'(exp_q.pop_front());
      check("rsp_missing", 64'd0, 64'd1);
    end
  end
  // reference model: register map and control rules at byte-address level
  t_hc_ctl_state m_state;
  bit m_req, m_start, m_dsm_set;
  logic [63:0] m_dsm;
  logic [63:0] m_addr[NB];
  logic [31:0] m_size[NB];
  bit m_aset[NB], m_sset[NB];
  task automatic m_reset();
    m_state = S_CTL_RESET; m_req = 0; m_start = 0; m_dsm_set = 0; m_dsm = '0;
    for (int i = 0; i < NB; i++) begin m_addr[i] = '0; m_size[i] = '0; m_aset[i] = 0; m_sset[i] = 0; end
  endtask
  function automatic bit m_ready();
    bit r = m_dsm_set;
    for (int i = 0; i < NB; i++) r &= m_aset[i] & m_sset[i];
    return r;
  endfunction
  function automatic logic [63:0] m_read(int b);
    if (b == MB) return m_dsm;
    if (b == MB + 8) return 64'(m_state);
    for (int i = 0; i < NB; i++) begin
      if (b == MB + 16 + 16 * i) return m_addr[i];
      if (b == MB + 24 + 16 * i) return {32'b0, m_size[i]};
    end
    return '0;
  endfunction
  task automatic m_apply(bit wr, int b, logic [63:0] d, bit done, bit ack);
    bit dec = wr && (b >> 2) < 'h100;
    bit ctl = dec && b == MB + 8;
    logic [31:0] c = d[31:0];
    m_start = 0;
    if (ack) m_req = 0;
    if (dec && b == MB) begin m_dsm = d; m_dsm_set = 1; end
    for (int i = 0; i < NB; i++) begin
      if (dec && b == MB + 16 + 16 * i) begin m_addr[i] = d; m_aset[i] = 1; end
      if (dec && b == MB + 24 + 16 * i) begin m_size[i] = d[31:0]; m_sset[i] = 1; end
    end
    if (ctl && c == 0) begin
      m_state = S_CTL_RESET; m_req = 0; m_dsm_set = 0;
      for (int i = 0; i < NB; i++) begin m_aset[i] = 0; m_sset[i] = 0; end
    end else if (ctl && c == 7 && (m_state == S_CTL_RUN || m_state == S_CTL_DONE)) begin
      m_state = S_CTL_IDLE; m_req = 0;
    end else if (ctl && c == 1 && m_state == S_CTL_RESET) m_state = S_CTL_IDLE;
    else if (ctl && c == 3 && m_state == S_CTL_IDLE && m_ready()) begin
      m_state = S_CTL_RUN; m_start = 1;
    end else if (done && m_state == S_CTL_RUN) begin m_state = S_CTL_DONE; m_req = 1; end
  endtask
  task automatic check_outputs();
    check("state", 64'(ctl_state), 64'(m_state));
    check("soft_reset", 64'(ctl_soft_reset), 64'(m_state == S_CTL_RESET));
    check("ctl_start", 64'(ctl_start), 64'(m_start));
    check("dsm_wr_req", 64'(dsm_wr_req), 64'(m_req));
    check("dsm_base", dsm_base, m_dsm);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("buf_addr%0d", i), buf_addr[i], m_addr[i]);
      check($sformatf("buf_size%0d", i), 64'(buf_size[i]), 64'(m_size[i]));
      check($sformatf("buf_valid%0d", i), 64'(buf_valid[i]), 64'(m_aset[i] && m_sset[i]));
    end
  endtask
  task automatic cycle(bit wr, bit rd, int b, logic [63:0] d, logic [8:0] tid, bit done, bit ack);
    rx.mmioWrValid = wr; rx.mmioRdValid = rd; rx.hdr.address = 16'(b >> 2);
    rx.hdr.tid = tid; rx.data = d; done_in = done; dsm_wr_ack = ack;
    if (rd) exp_q.push_back('{due: cyc + 1, tid: tid, data: m_read(b)});
    @(posedge clk); #1;
    m_apply(wr, b, d, done, ack);
    rx = '0; done_in = 0; dsm_wr_ack = 0;
    check_outputs();
  endtask
  task automatic wr_(int b, logic [63:0] d); cycle(1, 0, b, d, 9'd0, 0, 0); endtask
  task automatic rd_(int b, logic [8:0] tid); cycle(0, 1, b, '0, tid, 0, 0); endtask
  task automatic idle(int n); repeat (n) cycle(0, 0, 0, '0, 9'd0, 0, 0); endtask
  int addrs[12] = '{'h110, 'h118, 'h11C, 'h120, 'h124, 'h128, 'h130, 'h138, 'h140, 'h148, 'h100, 'h518};
  initial begin
    reset_n = 0; rx = '0; done_in = 0; dsm_wr_ack = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check("tx_valid_rst", 64'(tx.mmioRdValid), 64'd0);
    reset_n = 1;
    rd_('h118, 9'd5);
    wr_('h118, 64'd1);
    wr_('h120, 64'hDEAD_0000);
    wr_('h128, 64'd64);
    wr_('h118, 64'd3);
    check("start_partial", 64'(ctl_state), 64'(S_CTL_IDLE));
    wr_('h130, 64'hBEEF_0000);
    wr_('h138, 64'd128);
    check("buf_valid_both", 64'(buf_valid), 64'd3);
    rd_('h130, 9'd7);
    wr_('h140, 64'h1234_5678_9ABC_DEF0);
    wr_('h118, 64'd3);
    wr_('h110, 64'h8000_0000);
    wr_('h118, 64'hFFFF_FFFF_0000_0003);
    idle(1);
    cycle(0, 0, 0, '0, 9'd0, 1, 0);
    idle(5);
    cycle(0, 0, 0, '0, 9'd0, 0, 1);
    check("req_after_ack", 64'(dsm_wr_req), 64'd0);
    rd_('h118, 9'h1FF);
    wr_('h118, 64'd7);
    wr_('h118, 64'd3);
    cycle(1, 0, 'h118, 64'd7, 9'd0, 1, 0);
    wr_('h118, 64'd3);
    cycle(0, 0, 0, '0, 9'd0, 1, 0);
    idle(1);
    // asynchronous reset while dsm_wr_req is high and a read is in flight
    rx.mmioRdValid = 1; rx.hdr.address = 16'h46; rx.hdr.tid = 9'd9;
    #2 reset_n = 0;
    #1;
    check("arst_state", 64'(ctl_state), 64'(S_CTL_RESET));
    check("arst_soft", 64'(ctl_soft_reset), 64'd1);
    check("arst_req", 64'(dsm_wr_req), 64'd0);
    check("arst_valid", 64'(buf_valid), 64'd0);
    check("arst_dsm", dsm_base, 64'd0);
    check("arst_addr0", buf_addr[0], 64'd0);
    check("arst_tx", 64'(tx.mmioRdValid), 64'd0);
    rx = '0;
    @(posedge clk); #1;
    reset_n = 1;
    m_reset();
    check_outputs();
    for (int k = 0; k < 1500; k++) begin
      int r = $urandom_range(0, 99);
      int b = addrs[$urandom_range(0, 11)];
      logic [63:0] d = {$urandom, $urandom};
      int c = $urandom_range(0, 99);
      bit dn = $urandom_range(0, 9) == 0;
      bit ak = $urandom_range(0, 3) == 0;
      if (r < 35) begin
        if (r < 15) begin
          b = 'h118;
          d[31:0] = c < 4 ? 32'd0 : c < 30 ? 32'd1 : c < 65 ? 32'd3 : c < 85 ? 32'd7 : 32'(c);
        end
        cycle(1, 0, b, d, 9'd0, dn, ak);
      end else if (r < 70) cycle(0, 1, b, '0, 9'($urandom), dn, ak);
      else cycle(0, 0, 0, '0, 9'd0, dn, ak);
    end
    idle(2);
    check("rsp_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hc_csr_bank.md
HC_CSR_BANK -- requirements
Module: hc_csr_bank

Interface
REQ-001 Parameter NUM_BUFFERS, default 2, number of HardCloud buffer descriptors; legal range 1..8.
REQ-002 Parameter MMIO_BASE, default 16'h110, byte address of the DSM register; control sits at MMIO_BASE+8, buffers at MMIO_BASE+16.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx_mmio  in  t_if_ccip_c0_Rx  CCI-P MMIO request channel; mmioRdValid and mmioWrValid are never both high.
REQ-006 tx_mmio  out  t_if_ccip_c2_Tx  MMIO read response: valid, hdr.tid, 64b data.
REQ-007 dsm_base  out  64  DSM base byte address.
REQ-008 buf_addr  out  NUM_BUFFERS x 64  buffer base addresses.
REQ-009 buf_size  out  NUM_BUFFERS x 32  buffer sizes.
REQ-010 buf_valid  out  NUM_BUFFERS  bit i set once both address and size of buffer i are written.
REQ-011 ctl_state  out  t_hc_ctl_state  control FSM state.
REQ-012 ctl_soft_reset  out  1  held-reset signal to the datapath.
REQ-013 ctl_start  out  1  one-cycle start pulse.
REQ-014 done_in  in  1  datapath completion pulse.
REQ-015 dsm_wr_req  out  1 / dsm_wr_ack  in  1  request/ack handshake for the DSM completion write.

Function
REQ-016 A write is decoded only when mmioWrValid=1 and word address < 'h100; all others are ignored.
REQ-017 DSM write (word MMIO_BASE>>2) SHALL load all 64 data bits into dsm_base and set an internal dsm_set flag.
REQ-018 Buffer i address lives at byte MMIO_BASE+16+16*i, size at that +8; the decoded range is exactly [MMIO_BASE+16, MMIO_BASE+16+16*NUM_BUFFERS-8]; writes one word beyond it are ignored.
REQ-019 Buffer address writes take 64 data bits; size writes take data[31:0]; both update in the cycle after the request.
REQ-020 Control write (word (MMIO_BASE+8)>>2) with data[31:0] = 0 (ASSERT_RST), 1 (DEASSERT_RST), 3 (START) or 7 (STOP); any other value is ignored.
REQ-021 FSM states S_CTL_RESET, S_CTL_IDLE, S_CTL_RUN, S_CTL_DONE.
REQ-022 ASSERT_RST from any state -> S_CTL_RESET; also clears buf_valid and dsm_set and drops dsm_wr_req.
REQ-023 DEASSERT_RST in S_CTL_RESET -> S_CTL_IDLE.
REQ-024 START in S_CTL_IDLE with all buf_valid=1 and dsm_set=1 -> S_CTL_RUN, with ctl_start=1 for exactly that transition cycle; otherwise START is ignored.
REQ-025 done_in in S_CTL_RUN -> S_CTL_DONE and raises dsm_wr_req, which holds until the dsm_wr_ack cycle.
REQ-026 STOP in S_CTL_RUN or S_CTL_DONE -> S_CTL_IDLE and drops dsm_wr_req; a STOP in the same cycle as done_in wins.
REQ-027 ctl_soft_reset = 1 iff state is S_CTL_RESET.
REQ-028 done_in outside S_CTL_RUN is ignored.
REQ-029 mmioRdValid SHALL produce tx_mmio valid exactly 1 cycle later, echoing the tid.
REQ-030 Read data: the mapped register value, or {61'b0, ctl_state} for control; unmapped addresses return 0.
REQ-031 Back-to-back reads every cycle SHALL each get a response; there is no backpressure.

Reset
REQ-032 While reset_n=0, all registers clear asynchronously: dsm_base=0, buf_addr=0, buf_size=0, buf_valid=0, state=S_CTL_RESET, ctl_soft_reset=1, ctl_start=0, dsm_wr_req=0, tx_mmio valid=0.
REQ-033 A reset mid-handshake SHALL drop dsm_wr_req and any pending read response, with no response emitted after release.

Structure
REQ-034 Shared package grayscale_pkg holds HC_MAX_BUFFERS=8, the control action constants, the t_hc_ctl_state enum and the t_hc_buffer struct.
REQ-035 The FSM is the natural sub-module: hc_ctl_fsm (control decode in, state/pulses out); decode and read mux stay in hc_csr_bank.

Verification
REQ-036 Reset release, then read byte 0x118 tid=5 -> the next cycle returns tid=5, data=0 (S_CTL_RESET), and ctl_soft_reset=1.
REQ-037 With NUM_BUFFERS=2: write 0x120=0xDEAD_0000, 0x128=64, 0x130=0xBEEF_0000, 0x138=128 -> buf_valid=2'b11; read 0x130 returns 0xBEEF_0000; a write to 0x140 changes nothing.
REQ-038 START with only buffer 0 valid -> stays S_CTL_IDLE, ctl_start never pulses; after buffer 1 and DSM are written, START -> one ctl_start pulse, state S_CTL_RUN.
REQ-039 In S_CTL_RUN: done_in=1 -> dsm_wr_req=1 held for 5 cycles until dsm_wr_ack, then 0, state S_CTL_DONE.
REQ-040 Same-cycle STOP and done_in -> S_CTL_IDLE and dsm_wr_req stays 0; reset_n pulsed during dsm_wr_req -> all outputs reach their reset values immediately.
